usr_shift_reg: RTL
==================

// Module: usr_shift_reg
// PURPOSE
//  Parametrised universal shift register, successor to the single-bit SISO shifter.
//  DEPTH stages of WIDTH bits each, with four modes: hold, shift right, shift left, parallel load.
//  A shift counter tracks a loaded word being serialised and pulses done when it is fully out.
//  Used as a serialiser/deserialiser front end for the serial links.
// PARAMETERS
//  WIDTH  1  bits per stage (lane width)
//  DEPTH  4  number of stages (>=2)
// PORTS
//  clk    in   1            single clock; all state updates on posedge
//  rst    in   1            asynchronous, active-low reset (0 = reset)
//  en     in   1            operation enable; 0 = hold regardless of mode
//  mode   in   2            00 hold, 01 shift right, 10 shift left, 11 parallel load
//  sin_r  in   WIDTH        serial input entering stage DEPTH-1 on shift right
//  sin_l  in   WIDTH        serial input entering stage 0 on shift left
//  pin    in   WIDTH*DEPTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
//  sout_r out  WIDTH        serial output for right shift = stage[0]
//  sout_l out  WIDTH        serial output for left shift = stage[DEPTH-1]
//  pout   out  WIDTH*DEPTH  parallel view; stage i = pout[i*WIDTH +: WIDTH]
//  busy   out  1            1 while loaded word has shifts remaining (cnt != 0)
//  done   out  1            registered 1-cycle pulse when the last remaining shift completes
// BEHAVIOUR
//  - Reset (rst=0, async): all stages 0, cnt 0, done 0; so sout_r=sout_l=0, pout=0, busy=0.
//  - Release of rst is synchronised by the user; first active edge is the first posedge with rst=1.
//  - All outputs except done are combinational views of registers (no extra latency).
//  - en=0 or mode=00: stages, cnt hold; done <= 0.
//  - mode=01 (right): stage[i] <= stage[i+1] for i<DEPTH-1; stage[DEPTH-1] <= sin_r.
//    A value on sin_r appears on sout_r exactly DEPTH clock edges later.
//  - mode=10 (left): stage[i] <= stage[i-1] for i>0; stage[0] <= sin_l.
//    A value on sin_l appears on sout_l DEPTH edges later.
//  - mode=11 (load): stage[i] <= pin slice i; cnt <= DEPTH; done <= 0.
//  - Shift counter cnt, width $clog2(DEPTH+1):
//    each shift (01 or 10 with en=1) with cnt!=0 decrements cnt;
//    when cnt goes 1->0, done <= 1 for exactly one cycle; otherwise done <= 0.
//    Shifts with cnt==0 still move data; cnt stays 0, no done.
//  - Load while busy: cnt reloads to DEPTH, no done for the abandoned word.
//  - Mixed directions in one word count equally (each shift is one count).
//  - Reset mid-operation: immediate clear, busy drops, pending done is lost.
//  - No wrap: bits shifted out of the end are discarded (not rotated).
// TESTING (WIDTH=1, DEPTH=4 unless stated)
//  1 Reset: drive rst=0 mid-cycle with pout=4'b1011 -> pout=0, busy=0, done=0
//    immediately, before the next clk edge.
//  2 SISO right: rst=1, en=1, mode=01, sin_r sequence 1,0,1,0 on edges 1-4
//    -> sout_r = 1,0,1,0 on edges 4-7; pout=4'b0101 after edge 4.
//  3 Load + serialise: load pin=4'b1101, then 4 right shifts with sin_r=0
//    -> sout_r = 1,0,1,1 before each shift; busy=1 for 4 cycles;
//    done=1 only in the cycle after the 4th shift; pout=0 at end.
//  4 Left + hold: load 4'b0001, 2 left shifts with sin_l=1 -> pout=4'b0111;
//    then en=0 for 3 cycles -> pout, busy unchanged, done=0.
//  5 Reload while busy: load 4'hA, 2 shifts, load 4'h5, 4 shifts
//    -> exactly one done pulse, after the 6th shift overall.
//  6 WIDTH=8, DEPTH=3: load pin=24'hC3B2A1 -> sout_r=8'hA1;
//    two right shifts with sin_r=8'hFF -> pout=24'hFFFFC3.

Source files
------------

// File: rtl/usr_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial/parallel data and status.
interface usr_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       sin_r;
  logic [WIDTH-1:0]       sin_l;
  logic [WIDTH*DEPTH-1:0] pin;
  logic [WIDTH-1:0]       sout_r;
  logic [WIDTH-1:0]       sout_l;
  logic [WIDTH*DEPTH-1:0] pout;
  logic                   busy;
  logic                   done;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  sout_r, sout_l, pout, busy, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output sout_r, sout_l, pout, busy, done
  );
endinterface

// File: rtl/usr_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold/right/left/load,
// plus a shift counter that flags when a loaded word has been fully serialised.
module usr_shift_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] from_hi,
  input  logic [WIDTH-1:0] from_lo,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else if (en) begin
      case (mode)
        2'b01:   q <= from_hi;
        2'b10:   q <= from_lo;
        2'b11:   q <= load_val;
        default: q <= q;
      endcase
    end
  end
endmodule

module usr_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  usr_shift_reg_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0][WIDTH-1:0] hi;
  logic [DEPTH-1:0][WIDTH-1:0] lo;
  logic [CW-1:0]               cnt;
  logic                        done_q;
  logic                        shift;
  logic                        load;

  // Neighbour wiring: the end stages take the serial inputs instead of a neighbour.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == DEPTH - 1) begin : g_top
      assign hi[i] = bus.sin_r;
    end else begin : g_mid_hi
      assign hi[i] = stg[i+1];
    end
    if (i == 0) begin : g_bot
      assign lo[i] = bus.sin_l;
    end else begin : g_mid_lo
      assign lo[i] = stg[i-1];
    end

    usr_shift_stage #(.WIDTH(WIDTH)) u_stg (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .mode     (bus.mode),
      .from_hi  (hi[i]),
      .from_lo  (lo[i]),
      .load_val (bus.pin[i*WIDTH +: WIDTH]),
      .q        (stg[i])
    );
  end

  assign shift = bus.en && (bus.mode == 2'b01 || bus.mode == 2'b10);
  assign load  = bus.en && (bus.mode == 2'b11);

  // Load (re)arms the counter; abandoned words never produce done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) cnt <= CW'(DEPTH);
      else if (shift && cnt != '0) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) done_q <= 1'b1;
      end
    end
  end

  assign bus.pout   = stg;
  assign bus.sout_r = stg[0];
  assign bus.sout_l = stg[DEPTH-1];
  assign bus.busy   = (cnt != '0);
  assign bus.done   = done_q;
endmodule
